jedro_1_dram_arbiter: RTL and testbench

Two-master arbiter that shares the single data-RAM port (the `bytewrite_ram_wrap` stb/we/addr/wdata/rdata/ack/err bus) between the core load/store path (master 0) and a secondary requester such as a program loader or debug access unit (master 1). It sits between `jedro_1_top`'s `dram_*` port plus the secondary master on one side and the RAM wrapper on the other. It performs round-robin arbitration and latches the winning request, so the RAM sees a stable request until it responds. It routes the RAM's response back only to the granted master.

---
 rtl/jedro_1_dram_arbiter.sv | 155 +++++++++++++++
 tb/tb_jedro_1_dram_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jedro_1_dram_arbiter.sv
// Round-robin two-master arbiter in front of the data RAM port; latches the winning request until the RAM responds.
// Optional BUSY watchdog enabled by defining JEDRO_1_DRAM_ARB_TIMEOUT_EN.
module jedro_1_dram_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_stb,
  input  logic [DATA_WIDTH/8-1:0] m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  output logic                    m0_ack,
  output logic                    m0_err,
  input  logic                    m1_stb,
  input  logic [DATA_WIDTH/8-1:0] m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic                    s_stb,
  output logic [DATA_WIDTH/8-1:0] s_we,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  input  logic                    s_ack,
  input  logic                    s_err,
  output logic                    grant_o,
  output logic                    busy_o
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                  state_q, state_d;
  logic                    s_stb_q, s_stb_d;
  logic [DATA_WIDTH/8-1:0] s_we_q, s_we_d;
  logic [ADDR_WIDTH-1:0]   s_addr_q, s_addr_d;
  logic [DATA_WIDTH-1:0]   s_wdata_q, s_wdata_d;
  logic                    grant_q, grant_d;
  logic                    last_grant_q, last_grant_d;
  logic                    winner;
  logic                    timeout;

`ifdef JEDRO_1_DRAM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] tcnt_q, tcnt_d;

  // A slave response in the same cycle wins over the timeout.
  assign timeout = (state_q == BUSY) && !(s_ack || s_err) &&
                   (tcnt_q == CntW'(TIMEOUT_CYCLES));

  always_comb begin
    tcnt_d = tcnt_q;
    if (state_q == IDLE) begin
      tcnt_d = '0;
    end else if (!(s_ack || s_err)) begin
      tcnt_d = tcnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    s_stb_d      = s_stb_q;
    s_we_d       = s_we_q;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    winner       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0_stb || m1_stb) begin
          // On contention the master that was not served last wins.
          winner    = (m0_stb && m1_stb) ? ~last_grant_q : m1_stb;
          grant_d   = winner;
          s_stb_d   = 1'b1;
          s_we_d    = winner ? m1_we    : m0_we;
          s_addr_d  = winner ? m1_addr  : m0_addr;
          s_wdata_d = winner ? m1_wdata : m0_wdata;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (s_ack || s_err || timeout) begin
          last_grant_d = grant_q;
          s_stb_d      = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      s_stb_q      <= 1'b0;
      s_we_q       <= '0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      grant_q      <= 1'b1;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      s_stb_q      <= s_stb_d;
      s_we_q       <= s_we_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    m0_ack = 1'b0;
    m0_err = 1'b0;
    m1_ack = 1'b0;
    m1_err = 1'b0;
    if (state_q == BUSY) begin
      if (grant_q) begin
        m1_ack = s_ack;
        m1_err = s_err | timeout;
      end else begin
        m0_ack = s_ack;
        m0_err = s_err | timeout;
      end
    end
  end

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign s_stb    = s_stb_q;
  assign s_we     = s_we_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign grant_o  = grant_q;
  assign busy_o   = (state_q == BUSY);

endmodule

// File: tb/tb_jedro_1_dram_arbiter.sv
// Self-checking bench for jedro_1_dram_arbiter: RAM model, scoreboard of expected responses, one task per scenario.
`timescale 1ns/1ps
module tb_jedro_1_dram_arbiter;
`ifdef JEDRO_1_DRAM_ARB_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_stb = 1'b0, m1_stb = 1'b0;
  logic [3:0]  m0_we = '0, m1_we = '0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_stb;
  logic [3:0]  s_we;
  logic [31:0] s_addr, s_wdata;
  logic [31:0] s_rdata = '0;
  logic        s_ack, s_err;
  logic        grant_o, busy_o;

  logic        ram_ack = 1'b0;
  logic        man_ack = 1'b0, man_err = 1'b0;
  bit          ram_en = 1'b1;
  int          ram_lat = 1;
  int          ram_cnt = 0;
  logic [31:0] mem [0:63];

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          m;
    bit          is_err;
    bit          chk;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  assign s_ack = ram_ack | man_ack;
  assign s_err = man_err;

  always #5 clk = ~clk;

  jedro_1_dram_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack), .s_err(s_err),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  // RAM model: acks ram_lat cycles after s_stb rises; word 4 (addr 0x10) holds 2 after reset.
  always @(posedge clk) begin
    ram_ack <= 1'b0;
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[4]  <= 32'h2;
      ram_cnt <= 0;
    end else if (!s_stb || !ram_en) begin
      ram_cnt <= 0;
    end else if (!ram_ack) begin
      if (ram_cnt == ram_lat - 1) begin
        ram_ack <= 1'b1;
        s_rdata <= mem[s_addr[7:2]];
        for (int b = 0; b < 4; b++)
          if (s_we[b]) mem[s_addr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
        ram_cnt <= 0;
      end else begin
        ram_cnt <= ram_cnt + 1;
      end
    end
  end

  // Response monitor: every master response must match the head of the scoreboard.
  int          mon_m;
  logic        mon_ack, mon_err;
  logic [31:0] mon_rd;
  exp_t        e;
  always @(negedge clk) begin
    if (!rst && (m0_ack || m0_err || m1_ack || m1_err)) begin
      mon_m   = (m1_ack || m1_err) ? 1 : 0;
      mon_ack = mon_m ? m1_ack : m0_ack;
      mon_err = mon_m ? m1_err : m0_err;
      mon_rd  = mon_m ? m1_rdata : m0_rdata;
      checks++;
      if ((m0_ack || m0_err) && (m1_ack || m1_err)) begin
        errors++;
        $display("FAIL both_masters_resp: m0 ack/err=%b%b m1 ack/err=%b%b, required only one", m0_ack, m0_err, m1_ack, m1_err);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: m%0d got ack=%b err=%b, required no response", mon_m, mon_ack, mon_err);
      end else begin
        e = sb.pop_front();
        if (mon_m != e.m) begin
          errors++;
          $display("FAIL resp_master: got m%0d, required m%0d", mon_m, e.m);
        end
        checks++;
        if (grant_o !== 1'(e.m)) begin
          errors++;
          $display("FAIL resp_grant: grant_o=%b, required %0d", grant_o, e.m);
        end
        checks++;
        if ({mon_ack, mon_err} !== {~e.is_err, e.is_err}) begin
          errors++;
          $display("FAIL resp_kind: ack/err=%b%b, required %b%b", mon_ack, mon_err, ~e.is_err, e.is_err);
        end
        if (e.chk) begin
          checks++;
          if (mon_rd !== e.data) begin
            errors++;
            $display("FAIL resp_rdata: m%0d rdata=%h, required %h", mon_m, mon_rd, e.data);
          end
        end
      end
    end
  end

  function automatic exp_t mk(input int m, input bit is_err, input bit chk, input logic [31:0] d);
    exp_t r;
    r.m = m; r.is_err = is_err; r.chk = chk; r.data = d;
    return r;
  endfunction

  // Master drives its request from the current time and waits for its own response.
  task automatic txn(input int m, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
    int   cyc;
    logic seen;
    if (m == 0) begin m0_stb = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_stb = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; end
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      seen = (m == 0) ? (m0_ack || m0_err) : (m1_ack || m1_err);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL txn_response m%0d: none after %0d cycles, required a response", m, cyc);
    end
  endtask

  task automatic idle(input int m);
    if (m == 0) m0_stb = 1'b0;
    else        m1_stb = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m0_stb = 1'b0; m1_stb = 1'b0;
    man_ack = 1'b0; man_err = 1'b0;
    ram_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({s_stb, busy_o, grant_o, m0_ack, m0_err, m1_ack, m1_err} !== 7'b0010000) begin
      errors++;
      $display("FAIL reset_ctrl: stb,busy,grant,acks/errs=%b, required 0010000",
               {s_stb, busy_o, grant_o, m0_ack, m0_err, m1_ack, m1_err});
    end
    checks++;
    if ({s_we, s_addr, s_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: we=%h addr=%h wdata=%h, required all 0", s_we, s_addr, s_wdata);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    ram_lat = 1;
    sb.push_back(mk(0, 1'b0, 1'b1, 32'h2));
    m0_stb = 1'b1; m0_we = 4'h0; m0_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (s_stb !== 1'b1 || busy_o !== 1'b1 || s_addr !== 32'h10 || m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL single_stb: s_stb=%b busy=%b addr=%h ack=%b, required 1 1 00000010 0", s_stb, busy_o, s_addr, m0_ack);
    end
    @(negedge clk);
    checks++;
    if (m0_ack !== 1'b1 || m0_rdata !== 32'h2 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL single_ack: m0_ack=%b rdata=%h m1_ack=%b, required 1 00000002 0", m0_ack, m0_rdata, m1_ack);
    end
    idle(0);
    @(negedge clk);
    checks++;
    if (s_stb !== 1'b0 || m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL single_done: s_stb=%b m0_ack=%b, required 0 0", s_stb, m0_ack);
    end
  endtask

  task automatic test_both_requests();
    do_reset();
    ram_lat = 2;
    // m0 wins the first contention; when m0 re-requests at once, m1 wins the next one.
    sb.push_back(mk(0, 1'b0, 1'b0, '0));
    sb.push_back(mk(1, 1'b0, 1'b1, 32'h3));
    sb.push_back(mk(0, 1'b0, 1'b1, 32'h3));
    fork
      begin txn(0, 4'hF, 32'h20, 32'h3); txn(0, 4'h0, 32'h20, '0); idle(0); end
      begin txn(1, 4'h0, 32'h20, '0); idle(1); end
    join
  endtask

  task automatic test_back_to_back();
    do_reset();
    ram_lat = 2;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk(0, 1'b0, 1'b0, '0));
      sb.push_back(mk(1, 1'b0, 1'b1, 32'h100 + 32'(i)));
    end
    fork
      begin
        for (int i = 0; i < 4; i++) txn(0, 4'hF, 32'h40 + 32'(4*i), 32'h100 + 32'(i));
        idle(0);
      end
      begin
        for (int j = 0; j < 4; j++) txn(1, 4'h0, 32'h40 + 32'(4*j), '0);
        idle(1);
      end
    join
  endtask

  task automatic test_drop_stb();
    int   cyc;
    logic seen;
    do_reset();
    ram_lat = 4;
    sb.push_back(mk(0, 1'b0, 1'b0, '0));
    m0_stb = 1'b1; m0_we = 4'hF; m0_addr = 32'h30; m0_wdata = 32'hAA;
    @(negedge clk);
    m0_stb = 1'b0; m0_we = 4'h0; m0_addr = 32'h99; m0_wdata = 32'h0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      checks++;
      if (s_stb !== 1'b1 || s_addr !== 32'h30 || s_we !== 4'hF || s_wdata !== 32'hAA) begin
        errors++;
        $display("FAIL drop_hold: stb=%b addr=%h we=%h wdata=%h, required 1 00000030 f 000000aa", s_stb, s_addr, s_we, s_wdata);
      end
      @(negedge clk);
      cyc++;
      seen = m0_ack;
    end
    checks++;
    if (!seen || cyc != 4) begin
      errors++;
      $display("FAIL drop_ack: seen=%b after %0d cycles, required ack after 4", seen, cyc);
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || s_stb !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle: busy=%b s_stb=%b, required 0 0", busy_o, s_stb);
    end
    ram_lat = 1;
    sb.push_back(mk(0, 1'b0, 1'b1, 32'hAA));
    txn(0, 4'h0, 32'h30, '0);
    idle(0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    ram_en = 1'b0;
    m0_stb = 1'b1; m0_we = 4'hF; m0_addr = 32'h50; m0_wdata = 32'h55;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (s_stb !== 1'b0 || busy_o !== 1'b0 || grant_o !== 1'b1 || s_addr !== '0) begin
      errors++;
      $display("FAIL rstmid_state: s_stb=%b busy=%b grant=%b addr=%h, required 0 0 1 0", s_stb, busy_o, grant_o, s_addr);
    end
    rst = 1'b0;
    m0_stb = 1'b0;
    man_ack = 1'b1;
    #1;
    checks++;
    if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_late_ack: m0_ack=%b m1_ack=%b, required 0 0", m0_ack, m1_ack);
    end
    @(posedge clk);
    #1 man_ack = 1'b0;
    ram_en = 1'b1;
    @(negedge clk);
  endtask

`ifdef JEDRO_1_DRAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int   cyc;
    logic seen;
    do_reset();
    ram_en = 1'b0;
    sb.push_back(mk(0, 1'b1, 1'b0, '0));
    m0_stb = 1'b1; m0_we = 4'h0; m0_addr = 32'h10;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 50) begin
      @(negedge clk);
      cyc++;
      seen = m0_err;
    end
    idle(0);
    checks++;
    if (!seen || cyc != TO + 1) begin
      errors++;
      $display("FAIL timeout_err: seen=%b in BUSY cycle %0d, required cycle %0d", seen, cyc, TO + 1);
    end
    @(negedge clk);
    checks++;
    if (s_stb !== 1'b0 || m0_err !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_drop: s_stb=%b err=%b busy=%b, required 0 0 0", s_stb, m0_err, busy_o);
    end
    // Second case: response lands in the very cycle the timeout would fire.
    sb.push_back(mk(0, 1'b0, 1'b0, '0));
    m0_stb = 1'b1;
    repeat (TO + 1) @(posedge clk);
    #1 man_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (m0_ack !== 1'b1 || m0_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_tie: ack=%b err=%b, required 1 0", m0_ack, m0_err);
    end
    idle(0);
    @(posedge clk);
    #1 man_ack = 1'b0;
    ram_en = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_both_requests();
    test_back_to_back();
    test_drop_stb();
    test_reset_mid();
`ifdef JEDRO_1_DRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
